// File: rtl/imem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-port signals shared by the arbiter and its neighbours.
// slave = arbiter view, master = pipeline/memory view.
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 6
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_stall;
  logic              if_valid;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_stall;
  logic              d_valid;
  logic [31:0]       d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_stall, if_valid, if_rdata, d_stall, d_valid, d_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_stall, if_valid, if_rdata, d_stall, d_valid, d_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Single-port memory arbiter between IF and MEM stages with 1-cycle response routing.
// Optional fetch starvation guard enabled by defining FETCH_STARVE_GUARD_EN.
module imem_port_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int STARVE_MAX = 3
) (
  input logic                clk,
  input logic                rst_n,
  imem_port_arbiter_if.slave bus
);

  localparam logic [1:0] RSP_NONE = 2'd0;
  localparam logic [1:0] RSP_IF   = 2'd1;
  localparam logic [1:0] RSP_DRD  = 2'd2;
  localparam logic [1:0] RSP_DWR  = 2'd3;

  logic [1:0] rsp_st_q, rsp_st_d;
  logic       force_if;
  logic       grant_if;
  logic       grant_d;

`ifdef FETCH_STARVE_GUARD_EN
  logic [3:0] starve_cnt_q, starve_cnt_d;

  assign force_if = bus.if_req && (starve_cnt_q == 4'(STARVE_MAX));

  // Counts consecutive denied fetch cycles; saturates rather than wrapping.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.if_req || grant_if)
      starve_cnt_d = 4'd0;
    else if (starve_cnt_q != 4'hF)
      starve_cnt_d = starve_cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      starve_cnt_q <= 4'd0;
    else
      starve_cnt_q <= starve_cnt_d;
  end
`else
  assign force_if = 1'b0;
`endif

  // Data normally wins since MEM holds the older instruction.
  assign grant_if = bus.if_req && (!bus.d_req || force_if);
  assign grant_d  = bus.d_req && !grant_if;

  assign bus.if_stall = bus.if_req && !grant_if;
  assign bus.d_stall  = bus.d_req && !grant_d;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'h0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'h0;
    rsp_st_d      = RSP_NONE;
    if (grant_if) begin
      bus.mem_en   = 1'b1;
      bus.mem_be   = 4'hF;
      bus.mem_addr = bus.if_addr;
      rsp_st_d     = RSP_IF;
    end else if (grant_d) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.d_addr;
      if (bus.d_we) begin
        bus.mem_we    = 1'b1;
        bus.mem_be    = bus.d_be;
        bus.mem_wdata = bus.d_wdata;
        rsp_st_d      = RSP_DWR;
      end else begin
        bus.mem_be = 4'hF;
        rsp_st_d   = RSP_DRD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      rsp_st_q <= RSP_NONE;
    else
      rsp_st_q <= rsp_st_d;
  end

  assign bus.if_valid = (rsp_st_q == RSP_IF);
  assign bus.if_rdata = (rsp_st_q == RSP_IF) ? bus.mem_rdata : 32'h0;
  assign bus.d_valid  = (rsp_st_q == RSP_DRD) || (rsp_st_q == RSP_DWR);
  assign bus.d_rdata  = (rsp_st_q == RSP_DRD) ? bus.mem_rdata : 32'h0;

endmodule
